// File: rtl/branch_select_check_nw.sv
// IF-stage branch select/check: trims each fetch group at its first taken branch plus delay
// slot, redirects on a BTB disagreement, and compacts the surviving slots into a 2-entry buffer.
module branch_select_check_nw #(
    parameter int FW     = 4,
    parameter int CKPT_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            in_vaddr_i,
    input  logic [FW-1:0]          in_enable_i,
    input  logic [FW*32-1:0]       in_inst_i,
    input  logic [FW-1:0]          in_bpuTake_i,
    input  logic [FW*32-1:0]       in_bpuDest_i,
    input  logic [FW*CKPT_W-1:0]   in_ckpt_i,
    input  logic [FW-1:0]          in_btbEnable_i,
    input  logic                   in_btbTake_i,
    input  logic [31:0]            in_btbDest_i,
    input  logic                   in_exc_i,
    input  logic [4:0]             in_excCode_i,
    input  logic                   in_isRefill_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [FW*32-1:0]       out_inst_o,
    output logic [FW-1:0]          out_predTake_o,
    output logic [FW*32-1:0]       out_predDest_o,
    output logic [FW*CKPT_W-1:0]   out_ckpt_o,
    output logic [FW-1:0]          out_enable_o,
    output logic [$clog2(FW):0]    out_num_o,
    output logic [31:0]            out_basePC_o,
    output logic                   out_exc_o,
    output logic [4:0]             out_excCode_o,
    output logic                   out_isRefill_o,
    output logic                   redirect_o,
    output logic [31:0]            redirect_dest_o,
    output logic [31:0]            redirect_vaddr_o,
    output logic [CKPT_W-1:0]      redirect_ckpt_o,
    output logic [CNT_W-1:0]       miss_cnt_o
);
    localparam int NW = $clog2(FW) + 1;
    localparam int unsigned LAST = FW - 1;

    typedef enum logic {IDLE, WAIT_DS} stateT;

    typedef struct packed {
        logic [FW*32-1:0]     inst;
        logic [FW-1:0]        predTake;
        logic [FW*32-1:0]     predDest;
        logic [FW*CKPT_W-1:0] ckpt;
        logic [FW-1:0]        enable;
        logic [NW-1:0]        num;
        logic [31:0]          basePC;
        logic                 exc;
        logic [4:0]           excCode;
        logic                 isRefill;
    } entryT;

    stateT             state, stateNext;
    logic [1:0]        cnt;
    entryT             bufQ [2];
    entryT             newEntry;
    logic              acc, rd, wr;
    logic              found, evalTake, mism, redFire, saveDs;
    int unsigned       fPos, pcSlot, first, numCnt;
    logic [FW-1:0]     actMask;
    logic [31:0]       takeDest, redDestN, redVaddrN;
    logic [CKPT_W-1:0] redCkptN, pcCkpt;
    logic [31:0]       savedDest, savedVaddr;
    logic [CKPT_W-1:0] savedCkpt;
    logic              redQ;
    logic [31:0]       redDestQ, redVaddrQ;
    logic [CKPT_W-1:0] redCkptQ;
    logic [CNT_W-1:0]  missQ;

    assign in_ready_o  = (cnt < 2'd2);
    assign acc         = in_valid_i & in_ready_o & rst & ~flush_i;
    assign out_valid_o = (cnt != 2'd0);
    assign rd          = out_valid_o & out_ready_i;
    assign wr          = acc & (|actMask);

    always_comb begin
        found    = 1'b0;
        fPos     = 0;
        takeDest = in_vaddr_i + 32'(4 * FW);
        for (int unsigned k = 0; k < FW; k++) begin
            if (!found && in_enable_i[k] && in_bpuTake_i[k]) begin
                found    = 1'b1;
                fPos     = k;
                takeDest = in_bpuDest_i[k*32 +: 32];
            end
        end
        pcSlot = found ? fPos : LAST;
        pcCkpt = '0;
        for (int unsigned k = 0; k < FW; k++) begin
            if (k == pcSlot) pcCkpt = in_ckpt_i[k*CKPT_W +: CKPT_W];
        end

        actMask   = in_enable_i;
        stateNext = state;
        redFire   = 1'b0;
        saveDs    = 1'b0;
        mism      = 1'b0;
        evalTake  = 1'b0;
        if (in_exc_i) begin
            // an exception in the delay slot drops the pending redirect
            if (state == WAIT_DS) begin
                actMask[FW-1:1] = '0;
                stateNext       = IDLE;
            end
        end else if (state == WAIT_DS) begin
            actMask[FW-1:1] = '0;
            if (in_enable_i[0]) begin
                stateNext = IDLE;
                redFire   = 1'b1;
            end
        end else begin
            evalTake = found;
            if (found) begin
                for (int unsigned k = 0; k < FW; k++) begin
                    actMask[k] = in_enable_i[k] & (k <= fPos + 1);
                end
            end
            mism = (actMask != in_btbEnable_i) || (found != in_btbTake_i) ||
                   (found && in_btbTake_i && (takeDest != in_btbDest_i));
            if (found && fPos == LAST) begin
                saveDs    = 1'b1;
                stateNext = WAIT_DS;
            end else begin
                redFire = mism;
            end
        end
        if (!acc) begin
            stateNext = state;
            redFire   = 1'b0;
            saveDs    = 1'b0;
        end

        redDestN  = (state == WAIT_DS) ? savedDest  : takeDest;
        redVaddrN = (state == WAIT_DS) ? savedVaddr : in_vaddr_i + 32'(4 * pcSlot);
        redCkptN  = (state == WAIT_DS) ? savedCkpt  : pcCkpt;
    end

    // surviving slots are contiguous, so compaction is a shift down by the first survivor
    always_comb begin
        first  = 0;
        numCnt = 0;
        for (int unsigned k = 0; k < FW; k++) begin
            if (actMask[LAST-k]) first = LAST - k;
            numCnt = numCnt + 32'(actMask[k]);
        end
        newEntry = '0;
        for (int unsigned j = 0; j < FW; j++) begin
            for (int unsigned k = 0; k < FW; k++) begin
                if (j < numCnt && k == first + j) begin
                    newEntry.inst[j*32 +: 32]         = in_exc_i ? '0 : in_inst_i[k*32 +: 32];
                    newEntry.predTake[j]              = evalTake && (k == fPos);
                    newEntry.predDest[j*32 +: 32]     = in_bpuDest_i[k*32 +: 32];
                    newEntry.ckpt[j*CKPT_W +: CKPT_W] = in_ckpt_i[k*CKPT_W +: CKPT_W];
                    newEntry.enable[j]                = 1'b1;
                end
            end
        end
        newEntry.num      = NW'(numCnt);
        newEntry.basePC   = in_vaddr_i + 32'(4 * first);
        newEntry.exc      = in_exc_i;
        newEntry.excCode  = in_exc_i ? in_excCode_i : '0;
        newEntry.isRefill = in_exc_i & in_isRefill_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bufQ[0]    <= '0;
            bufQ[1]    <= '0;
            savedDest  <= '0;
            savedVaddr <= '0;
            savedCkpt  <= '0;
            redQ       <= 1'b0;
            redDestQ   <= '0;
            redVaddrQ  <= '0;
            redCkptQ   <= '0;
            missQ      <= '0;
        end else begin
            if (redirect_o && !(&missQ)) missQ <= missQ + CNT_W'(1);
            if (flush_i) begin
                state      <= IDLE;
                cnt        <= '0;
                redQ       <= 1'b0;
                savedDest  <= '0;
                savedVaddr <= '0;
                savedCkpt  <= '0;
            end else begin
                state <= stateNext;
                redQ  <= redFire;
                if (redFire) begin
                    redDestQ  <= redDestN;
                    redVaddrQ <= redVaddrN;
                    redCkptQ  <= redCkptN;
                end
                if (saveDs) begin
                    savedDest  <= takeDest;
                    savedVaddr <= in_vaddr_i + 32'(4 * fPos);
                    savedCkpt  <= pcCkpt;
                end
                if (rd) bufQ[0] <= bufQ[1];
                if (wr) begin
                    if (cnt == 2'd1 && !rd) bufQ[1] <= newEntry;
                    else                    bufQ[0] <= newEntry;
                end
                cnt <= cnt + {1'b0, wr} - {1'b0, rd};
            end
        end
    end

    assign out_inst_o       = bufQ[0].inst;
    assign out_predTake_o   = bufQ[0].predTake;
    assign out_predDest_o   = bufQ[0].predDest;
    assign out_ckpt_o       = bufQ[0].ckpt;
    assign out_enable_o     = bufQ[0].enable;
    assign out_num_o        = bufQ[0].num;
    assign out_basePC_o     = bufQ[0].basePC;
    assign out_exc_o        = bufQ[0].exc;
    assign out_excCode_o    = bufQ[0].excCode;
    assign out_isRefill_o   = bufQ[0].isRefill;
    // a flush in the pulse cycle cancels the redirect
    assign redirect_o       = redQ & ~flush_i;
    assign redirect_dest_o  = redDestQ;
    assign redirect_vaddr_o = redVaddrQ;
    assign redirect_ckpt_o  = redCkptQ;
    assign miss_cnt_o       = missQ;
endmodule

// File: tb/tb_branch_select_check_nw.sv
// Bench for branch_select_check_nw: directed groups then random traffic, checked each cycle
// against a queue-based reference of the fetch-group rules.
module tb_branch_select_check_nw;
    localparam int FW = 4;
    localparam int CKPT_W = 24;
    localparam int CNT_W = 4;
    localparam int NW = 3;

    logic clk = 1'b0;
    logic rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0] in_vaddr_i, in_btbDest_i, out_basePC_o, redirect_dest_o, redirect_vaddr_o;
    logic [FW-1:0] in_enable_i, in_bpuTake_i, in_btbEnable_i, out_predTake_o, out_enable_o;
    logic [FW*32-1:0] in_inst_i, in_bpuDest_i, out_inst_o, out_predDest_o;
    logic [FW*CKPT_W-1:0] in_ckpt_i, out_ckpt_o;
    logic in_btbTake_i, in_exc_i, in_isRefill_i, out_exc_o, out_isRefill_o, redirect_o;
    logic [4:0] in_excCode_i, out_excCode_o;
    logic [NW-1:0] out_num_o;
    logic [CKPT_W-1:0] redirect_ckpt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    branch_select_check_nw #(.FW(FW), .CKPT_W(CKPT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_vaddr_i(in_vaddr_i),
        .in_enable_i(in_enable_i), .in_inst_i(in_inst_i), .in_bpuTake_i(in_bpuTake_i),
        .in_bpuDest_i(in_bpuDest_i), .in_ckpt_i(in_ckpt_i), .in_btbEnable_i(in_btbEnable_i),
        .in_btbTake_i(in_btbTake_i), .in_btbDest_i(in_btbDest_i), .in_exc_i(in_exc_i),
        .in_excCode_i(in_excCode_i), .in_isRefill_i(in_isRefill_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_inst_o(out_inst_o),
        .out_predTake_o(out_predTake_o), .out_predDest_o(out_predDest_o),
        .out_ckpt_o(out_ckpt_o), .out_enable_o(out_enable_o), .out_num_o(out_num_o),
        .out_basePC_o(out_basePC_o), .out_exc_o(out_exc_o), .out_excCode_o(out_excCode_o),
        .out_isRefill_o(out_isRefill_o), .redirect_o(redirect_o),
        .redirect_dest_o(redirect_dest_o), .redirect_vaddr_o(redirect_vaddr_o),
        .redirect_ckpt_o(redirect_ckpt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW*32-1:0]     inst;
        logic [FW-1:0]        predTake;
        logic [FW*32-1:0]     predDest;
        logic [FW*CKPT_W-1:0] ckpt;
        logic [FW-1:0]        enable;
        logic [NW-1:0]        num;
        logic [31:0]          basePC;
        logic                 exc;
        logic [4:0]           excCode;
        logic                 isRefill;
    } expT;

    expT expQ[$];
    bit waitDs, redPend;
    logic [31:0] sDest, sPc, rDest, rPc;
    logic [CKPT_W-1:0] sCkpt, rCkpt;
    int unsigned missExp;
    int errCnt = 0;
    int chkCnt = 0;

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What the group resolves to when evaluated outside a delay slot.
    function automatic void idlePredict(input logic [FW-1:0] en, input logic [FW-1:0] tk,
                                        input logic [FW*32-1:0] dests, input logic [31:0] va,
                                        output int f, output logic [FW-1:0] mask,
                                        output bit take, output logic [31:0] dest);
        f = -1;
        for (int k = 0; k < FW; k++) if (f < 0 && en[k] && tk[k]) f = k;
        take = (f >= 0);
        dest = take ? dests[f*32 +: 32] : va + 4 * FW;
        mask = en;
        for (int k = 0; k < FW; k++) if (take && k > f + 1) mask[k] = 1'b0;
    endfunction

    task automatic modelAccept();
        int f, s, pcSlot;
        logic [FW-1:0] mask;
        bit take, wasWait;
        logic [31:0] dest;
        int idx[$];
        expT e;
        wasWait = waitDs;
        idlePredict(in_enable_i, in_bpuTake_i, in_bpuDest_i, in_vaddr_i, f, mask, take, dest);
        if (in_exc_i) begin
            mask = in_enable_i;
            if (wasWait) mask[FW-1:1] = '0;
            waitDs = 1'b0;
        end else if (wasWait) begin
            mask = in_enable_i;
            mask[FW-1:1] = '0;
            if (in_enable_i[0]) begin
                redPend = 1'b1; rDest = sDest; rPc = sPc; rCkpt = sCkpt; waitDs = 1'b0;
            end
        end else if (f == FW - 1) begin
            waitDs = 1'b1; sDest = dest; sPc = in_vaddr_i + 4 * f;
            sCkpt = in_ckpt_i[f*CKPT_W +: CKPT_W];
        end else if (mask != in_btbEnable_i || take != in_btbTake_i ||
                     (take && in_btbTake_i && dest != in_btbDest_i)) begin
            pcSlot = take ? f : FW - 1;
            redPend = 1'b1; rDest = dest; rPc = in_vaddr_i + 4 * pcSlot;
            rCkpt = in_ckpt_i[pcSlot*CKPT_W +: CKPT_W];
        end
        for (int k = 0; k < FW; k++) if (mask[k]) idx.push_back(k);
        if (idx.size() > 0) begin
            e = '0;
            for (int j = 0; j < idx.size(); j++) begin
                s = idx[j];
                e.inst[j*32 +: 32] = in_exc_i ? 32'h0 : in_inst_i[s*32 +: 32];
                e.predTake[j] = !in_exc_i && !wasWait && (s == f);
                e.predDest[j*32 +: 32] = in_bpuDest_i[s*32 +: 32];
                e.ckpt[j*CKPT_W +: CKPT_W] = in_ckpt_i[s*CKPT_W +: CKPT_W];
                e.enable[j] = 1'b1;
            end
            e.num = NW'(idx.size());
            e.basePC = in_vaddr_i + 4 * idx[0];
            e.exc = in_exc_i;
            e.excCode = in_exc_i ? in_excCode_i : 5'h0;
            e.isRefill = in_exc_i & in_isRefill_i;
            expQ.push_back(e);
        end
    endtask

    // Inputs are driven at the negedge; outputs checked 1ns later; model steps to the posedge.
    task automatic stepCycle();
        bit expRed, accE;
        #1;
        checkVal("inReady", in_ready_o, expQ.size() < 2);
        checkVal("outValid", out_valid_o, expQ.size() > 0);
        if (expQ.size() > 0) begin
            checkVal("outInst", out_inst_o, expQ[0].inst);
            checkVal("outPredTake", out_predTake_o, expQ[0].predTake);
            checkVal("outPredDest", out_predDest_o, expQ[0].predDest);
            checkVal("outCkpt", out_ckpt_o, expQ[0].ckpt);
            checkVal("outEnable", out_enable_o, expQ[0].enable);
            checkVal("outNum", out_num_o, expQ[0].num);
            checkVal("outBasePC", out_basePC_o, expQ[0].basePC);
            checkVal("outExc", {out_exc_o, out_excCode_o, out_isRefill_o},
                     {expQ[0].exc, expQ[0].excCode, expQ[0].isRefill});
        end
        expRed = redPend && !flush_i;
        checkVal("redirect", redirect_o, expRed);
        if (expRed) begin
            checkVal("redirectDest", redirect_dest_o, rDest);
            checkVal("redirectVaddr", redirect_vaddr_o, rPc);
            checkVal("redirectCkpt", redirect_ckpt_o, rCkpt);
        end
        checkVal("missCnt", miss_cnt_o, missExp);
        if (expRed && missExp < (1 << CNT_W) - 1) missExp++;
        redPend = 1'b0;
        if (flush_i) begin
            expQ.delete();
            waitDs = 1'b0;
        end else begin
            accE = in_valid_i && expQ.size() < 2;
            if (expQ.size() > 0 && out_ready_i) void'(expQ.pop_front());
            if (accE) modelAccept();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setGroup(input logic [31:0] va, input logic [FW-1:0] en, input logic [FW-1:0] tk,
                            input logic [31:0] dest, input logic [FW-1:0] bEn, input bit bTk,
                            input logic [31:0] bDest, input bit exc);
        in_valid_i = 1'b1; in_vaddr_i = va; in_enable_i = en; in_bpuTake_i = tk;
        for (int k = 0; k < FW; k++) begin
            in_inst_i[k*32 +: 32] = 32'hC000_0000 ^ (va + 4 * k);
            in_bpuDest_i[k*32 +: 32] = dest;
            in_ckpt_i[k*CKPT_W +: CKPT_W] = CKPT_W'(va >> 2) + CKPT_W'(k);
        end
        in_btbEnable_i = bEn; in_btbTake_i = bTk; in_btbDest_i = bDest;
        in_exc_i = exc; in_excCode_i = 5'h2; in_isRefill_i = exc;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic randomInputs();
        int lo, hi, f;
        logic [FW-1:0] pMask;
        bit pTake;
        logic [31:0] pDest;
        in_valid_i = ($urandom_range(0, 4) != 0);
        out_ready_i = ($urandom_range(0, 3) != 0);
        flush_i = ($urandom_range(0, 19) == 0);
        in_vaddr_i = $urandom & 32'hFFFF_FFF0;
        lo = $urandom_range(0, FW - 1);
        hi = $urandom_range(lo, FW - 1);
        if ($urandom_range(0, 2) == 0) begin lo = 0; hi = FW - 1; end
        in_enable_i = '0;
        for (int k = lo; k <= hi; k++) in_enable_i[k] = 1'b1;
        if ($urandom_range(0, 31) == 0) in_enable_i = '0;
        for (int k = 0; k < FW; k++) begin
            in_bpuTake_i[k] = ($urandom_range(0, 4) == 0);
            in_inst_i[k*32 +: 32] = $urandom;
            in_bpuDest_i[k*32 +: 32] = $urandom & 32'hFFFF_FFFC;
            in_ckpt_i[k*CKPT_W +: CKPT_W] = CKPT_W'($urandom);
        end
        idlePredict(in_enable_i, in_bpuTake_i, in_bpuDest_i, in_vaddr_i, f, pMask, pTake, pDest);
        if ($urandom_range(0, 1) == 0) begin
            in_btbEnable_i = pMask; in_btbTake_i = pTake; in_btbDest_i = pDest;
        end else begin
            in_btbEnable_i = FW'($urandom);
            in_btbTake_i = $urandom_range(0, 1) == 1;
            in_btbDest_i = ($urandom_range(0, 1) == 1) ? pDest : ($urandom & 32'hFFFF_FFFC);
        end
        in_exc_i = ($urandom_range(0, 9) == 0);
        in_excCode_i = 5'($urandom);
        in_isRefill_i = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        setGroup(32'h0, '0, '0, 32'h0, '0, 1'b0, 32'h0, 1'b0);
        in_valid_i = 1'b0;
        waitDs = 1'b0; redPend = 1'b0; missExp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkVal("rstOutValid", out_valid_o, 1'b0);
        checkVal("rstRedirect", redirect_o, 1'b0);
        checkVal("rstMissCnt", miss_cnt_o, 0);
        checkVal("rstData", {out_inst_o, out_num_o, out_basePC_o, redirect_dest_o}, 0);
        rst = 1'b1;
        @(negedge clk);
        idle(1);

        // taken at slot 1, BTB agrees
        setGroup(32'h1000, 4'b1111, 4'b0010, 32'h2000, 4'b0111, 1'b1, 32'h2000, 1'b0);
        stepCycle(); idle(2);
        // same group, BTB said not-taken
        setGroup(32'h1000, 4'b1111, 4'b0010, 32'h2000, 4'b1111, 1'b0, 32'h0, 1'b0);
        stepCycle(); idle(3);
        // taken at last slot; delay slot in next group
        setGroup(32'h1000, 4'b1111, 4'b1000, 32'h3000, 4'b1111, 1'b1, 32'h3000, 1'b0);
        stepCycle();
        setGroup(32'h1010, 4'b1111, 4'b0000, 32'h0, 4'b1111, 1'b0, 32'h0, 1'b0);
        stepCycle(); idle(3);
        // partially enabled group
        setGroup(32'h1000, 4'b1100, 4'b0000, 32'h0, 4'b1100, 1'b0, 32'h0, 1'b0);
        stepCycle(); idle(2);
        // backpressure
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setGroup(32'h2000 + 32'(16 * i), 4'b1111, 4'b0000, 32'h0, 4'b1111, 1'b0, 32'h0, 1'b0);
            stepCycle();
        end
        out_ready_i = 1'b1;
        idle(4);
        // flush while waiting for a delay slot
        setGroup(32'h1000, 4'b1111, 4'b1000, 32'h3000, 4'b1111, 1'b1, 32'h3000, 1'b0);
        stepCycle();
        in_valid_i = 1'b0; flush_i = 1'b1;
        stepCycle();
        flush_i = 1'b0;
        setGroup(32'h4000, 4'b1111, 4'b0000, 32'h0, 4'b1111, 1'b0, 32'h0, 1'b0);
        stepCycle(); idle(3);
        // flush in the pulse cycle cancels the redirect
        setGroup(32'h5000, 4'b1111, 4'b0001, 32'h6000, 4'b1111, 1'b0, 32'h0, 1'b0);
        stepCycle();
        in_valid_i = 1'b0; flush_i = 1'b1;
        stepCycle();
        flush_i = 1'b0;
        idle(2);
        // exception arriving as the delay slot
        setGroup(32'h7000, 4'b1111, 4'b1000, 32'h8000, 4'b1111, 1'b1, 32'h8000, 1'b0);
        stepCycle();
        setGroup(32'h7010, 4'b1111, 4'b0000, 32'h0, 4'b1111, 1'b0, 32'h0, 1'b1);
        stepCycle(); idle(3);

        for (int c = 0; c < 2500; c++) begin
            randomInputs();
            stepCycle();
        end
        flush_i = 1'b0; out_ready_i = 1'b1;
        idle(5);
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule

// File: doc/branch_select_check_nw.md
# branch_select_check_nw

Parametrised, registered successor of the IF-stage branch select/check logic. It accepts one fetch group of `FW` slots per handshake. From per-slot BPU decisions it finds the first taken branch and trims the enable mask to that branch and its delay slot. It checks the result against the early BTB prediction, issues a one-cycle redirect on disagreement, and tracks a delay slot that falls outside the group across group boundaries with an FSM. It compacts surviving slots into a 2-entry output buffer that feeds the instruction FIFO over valid/ready.

## Interface
- `FW`, 4: slots per fetch group; power of two, 2..8.
- `CKPT_W`, 24: per-slot BPU checkpoint width.
- `CNT_W`, 16: width of the misprediction counter.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous and active-low.
- `flush_i` in 1: backend flush (exception or branch repair).
- `in_valid_i` in 1 / `in_ready_o` out 1: upstream handshake.
- `in_vaddr_i` in 32: group base address; bits `[log2(FW)+1:0]` are zero.
- `in_enable_i` in FW: fetched-slot mask, contiguous.
- `in_inst_i` in FW*32: instructions, slot k at `[32k+31:32k]`.
- `in_bpuTake_i` in FW / `in_bpuDest_i` in FW*32: per-slot BPU take and target.
- `in_ckpt_i` in FW*CKPT_W: per-slot checkpoints.
- `in_btbEnable_i` in FW, `in_btbTake_i` in 1, `in_btbDest_i` in 32: early BTB prediction.
- `in_exc_i` in 1, `in_excCode_i` in 5, `in_isRefill_i` in 1: fetch exception.
- `out_valid_o` out 1 / `out_ready_i` in 1: FIFO handshake.
- `out_inst_o` FW*32, `out_predTake_o` FW, `out_predDest_o` FW*32, `out_ckpt_o` FW*CKPT_W: compacted slots; slot 0 is the first surviving slot.
- `out_enable_o` FW: thermometer mask of compacted slots.
- `out_num_o` log2(FW)+1: number of compacted slots.
- `out_basePC_o` 32: address of compacted slot 0.
- `out_exc_o` 1, `out_excCode_o` 5, `out_isRefill_o` 1: exception outputs.
- `redirect_o` out 1, `redirect_dest_o` out 32, `redirect_vaddr_o` out 32, `redirect_ckpt_o` out CKPT_W: redirect pulse, target, branch PC and branch checkpoint.
- `miss_cnt_o` out CNT_W: saturating count of redirects.

## Operation
- Accept: `acc = in_valid_i & in_ready_o & rst & !flush_i`. `in_ready_o = (cnt < 2)`.
- Evaluation, state IDLE, no exception:
  - f = lowest k with `in_enable_i[k] & in_bpuTake_i[k]`.
  - If f exists and f < FW-1: actual mask = enabled slots 0..f+1. Take = 1, dest = `in_bpuDest_i[f]`.
  - If f = FW-1: actual mask = enabled slots 0..f. Save dest and checkpoint, enter WAIT_DS.
  - If no f: actual mask = `in_enable_i`, take = 0, dest = `in_vaddr_i + 4*FW`.
- Check, IDLE only: mismatch if `actual != in_btbEnable_i`, or take differs from `in_btbTake_i`, or both take and dest differ. When f = FW-1, mismatch is evaluated but the redirect is deferred to the delay slot.
- WAIT_DS: the accepted group is the sequential successor.
  - Actual mask = slot 0 only.
  - Redirect to the saved dest unconditionally; return to IDLE.
  - If `in_enable_i[0]=0`, write nothing and stay in WAIT_DS.
- Exception group: instructions forced to 0, branch evaluation skipped, actual mask = `in_enable_i`, no redirect. In WAIT_DS, slot 0 only and a return to IDLE with the pending redirect dropped.
- Compaction: surviving slots are packed in ascending order. `out_basePC_o = in_vaddr_i + 4*first`, where `first` is the lowest surviving slot.
- Groups with an empty actual mask are consumed without a buffer write.
- Buffer: 2 entries with `cnt` 0..2. Write on acc with a non-empty mask; read on `out_valid_o & out_ready_i`. Simultaneous write and read with cnt=2 is impossible because `in_ready_o=0`.
- Flush: `cnt←0`, FSM→IDLE, saved target discarded, pending redirect suppressed. Flush has priority over every same-cycle event.
- `miss_cnt_o` increments on each `redirect_o` pulse and saturates at all-ones.

## Timing
- Reset values, with `rst`=0 at a clock edge: `cnt=0`, FSM=IDLE, `out_valid_o=0`, `redirect_o=0`, `miss_cnt_o=0`. All registered data outputs are 0. `in_ready_o` is 1 the cycle after reset.
- Accept to `out_valid_o`: 1 cycle when the buffer is empty.
- `redirect_o`: registered, high for exactly the one cycle after the deciding acceptance. Dest, vaddr and checkpoint are valid only in that cycle.
- `redirect_vaddr_o` carries the branch PC, also for a delayed-slot redirect.
- `flush_i` in the cycle after an acceptance cancels that acceptance's redirect pulse: the pulse is cleared at the same edge.
- Full throughput is one group per cycle while `out_ready_i=1`.

## Test plan
- FW=4, vaddr 0x1000, enable 1111, take at slot 1 to 0x2000, BTB agrees with mask 0111 -> output num=3, basePC 0x1000; no redirect.
- Same group with BTB predicting not-taken, mask 1111 -> `redirect_o` pulses 1 cycle after accept with dest 0x2000 and vaddr 0x1004; `miss_cnt_o`=1.
- Take at slot 3 to 0x3000, then group 0x1010 with enable 1111 -> first output 4 slots; second output 1 slot at basePC 0x1010; redirect to 0x3000 with vaddr 0x100C.
- Enable 1100 at 0x1000, no take -> basePC 0x1008, num=2, compacted mask 0011.
- `out_ready_i`=0 for 3 groups -> `in_ready_o` drops after 2; data order is preserved on release.
- WAIT_DS state followed by `flush_i` -> next group evaluated in IDLE; no redirect; cnt=0; `miss_cnt_o` unchanged.
